chunked_ripple_adder: RTL
=========================

Name: chunked_ripple_adder

Overview:
- Parametrised multi-cycle ripple adder/subtractor; successor to the fixed 4-bit combinational ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock. The carry is registered between chunks, trading latency for a short critical path.
- Valid/ready handshakes on input and output. Used by the arithmetic datapath feeding the hex seven-segment display path.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits summed per clock; NCHUNK = WIDTH/CHUNK. CHUNK = WIDTH gives a single-cycle add.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add; borrow-in for subtract.
- sub  in  1  0 = a+b+cin; 1 = a-b-cin.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, registered.
- cout  out  1  carry-out for add; not-borrow for subtract (1 means a >= b+cin).
- ovf  out  1  signed overflow; present only with CHUNKED_ADDER_OVF_EN.

Behaviour:
- Reset (rst_n sampled low at a clk edge):
  - state goes to IDLE; chunk index k = 0.
  - sum = 0, cout = 0, out_valid = 0, ovf = 0.
  - in_ready = 1 from the first cycle after reset.
  - An operation in flight is aborted and no result is emitted.
- States: IDLE, RUN, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE:
  - On in_valid && in_ready:
    - latch a_r = a and b_r = sub ? ~b : b.
    - load carry = cin ^ sub; clear sum to 0; set k = 0; go to RUN.
  - Without in_valid, stay in IDLE.
- RUN:
  - Each cycle: {c, s} = a_r[k*CHUNK +: CHUNK] + b_r[k*CHUNK +: CHUNK] + carry (CHUNK+1-bit result).
  - Write s to sum[k*CHUNK +: CHUNK]; carry <= c; k <= k+1.
  - When k == NCHUNK-1: cout <= c and go to DONE.
  - in_valid is ignored here; in_ready = 0.
- DONE:
  - sum and cout are held stable while out_valid = 1.
  - On out_ready, go to IDLE next edge.
  - No same-cycle accept: in_ready rises one cycle after the output handshake.
- Latency: the accept edge is E0. out_valid is high after edge E(NCHUNK), i.e. NCHUNK cycles later.
- Throughput: at best one operation per NCHUNK+2 cycles.
- Arithmetic: results are modulo 2^WIDTH; the carry out of the top chunk drives cout only.
  - Subtract uses two's complement: a + ~b + (1 - cin).
- sum is undefined for consumers while RUN; it is only meaningful when out_valid = 1.
- a, b, cin and sub may change freely after acceptance; latched copies are used.
- Simultaneous rst_n low with any handshake: reset wins.
- out_ready asserted in IDLE or RUN has no effect.

Optional Feature:
- Macro: CHUNKED_ADDER_OVF_EN.
- When defined:
  - ovf port exists.
  - On entry to DONE: ovf <= (carry into MSB) XOR (carry out of MSB), i.e. the operand sign bits a_r and b_r agree and differ from the sum sign.
  - ovf is held with sum; reset value 0.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n low 2 cycles mid-idle -> out_valid=0, sum=0, cout=0, in_ready=1 the cycle after release.
- Full carry ripple (WIDTH=16, CHUNK=4): a=0xFFFF, b=0x0001, cin=0, sub=0 -> out_valid exactly 4 cycles after accept, sum=0x0000, cout=1.
- Subtract:
  - a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0.
  - a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
  - a=0x0007, b=0x0005, cin=1 -> sum=0x0001, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles and pulse in_valid with new operands -> sum/cout stable, in_ready=0, pulses ignored; result consumed once; in_ready=1 the cycle after.
- Abort: drop rst_n after 2 RUN cycles, then issue a=0x1234, b=0x1111 -> first operation never produces out_valid; second gives sum=0x2345, cout=0.
- OVF and sweep with CHUNKED_ADDER_OVF_EN defined:
  - a=0x7FFF, b=0x0001 add -> ovf=1.
  - a=0x8000, b=0x0001 sub -> ovf=1.
  - a=0x0003, b=0x0004 add -> ovf=0.
  - Randomised compare against a+b+cin / a-b-cin for CHUNK=1, 4 and 16.

Source files
------------

// File: rtl/chunked_ripple_adder.sv
// Multi-cycle ripple add/sub, CHUNK bits per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by CHUNKED_ADDER_OVF_EN.
module chunked_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CHUNK:0]   chunk_w;

  // One chunk of the ripple: the carry between chunks lives in carry_q.
  assign chunk_w = {1'b0, a_q[k_q*CHUNK +: CHUNK]}
                 + {1'b0, b_q[k_q*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          sum_d   = '0;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      (state_q == S_RUN): begin
        sum_d[k_q*CHUNK +: CHUNK] = chunk_w[CHUNK-1:0];
        carry_d = chunk_w[CHUNK];
        k_d     = k_q + 1'b1;
        if (k_q == KW'(NCHUNK - 1)) begin
          cout_d  = chunk_w[CHUNK];
          // Same-sign operands giving a different-sign result.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                 && (chunk_w[CHUNK-1] != a_q[WIDTH-1]);
          state_d = S_DONE;
        end
      end
      (state_q == S_DONE): begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef CHUNKED_ADDER_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q ^ ovf_d;
`endif

endmodule
